// File: rtl/hci_l2_xbar_lat_pkg.sv
// hci_package: shared constants and response-pipeline entry for the L2 crossbar.
// The index field is sized for the largest supported initiator count (2**IDX_W).
package hci_package;
  localparam int MEM_LAT_MIN = 1;
  localparam int MEM_LAT_MAX = 4;
  localparam int IDX_W       = 8;
  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } rsp_entry_t;
endpackage

// File: rtl/hci_l2_xbar_lat_rr_arbiter.sv
// hci_l2_rr_arbiter: round-robin arbiter for one bank.
// The pointer moves just past the winner, and only on a transfer the bank accepted.
module hci_l2_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_en,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_fire
);
  logic [IW-1:0] r_ptr;
  logic          w_any;
  int            w_j;
  always_comb begin
    w_any = 1'b0;
    o_idx = '0;
    w_j   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_j = int'(r_ptr) + k;
      if (w_j >= N_REQ) w_j = w_j - N_REQ;
      if (!w_any && i_req[w_j]) begin
        w_any = 1'b1;
        o_idx = IW'(w_j);
      end
    end
  end
  assign o_fire = i_en & w_any;
  assign o_gnt  = o_fire ? N_REQ'(1) << o_idx : '0;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ptr <= '0;
    else if (o_fire) r_ptr <= (o_idx == IW'(N_REQ - 1)) ? '0 : o_idx + IW'(1);
  end
endmodule

// File: rtl/hci_l2_xbar_lat.sv
// hci_l2_xbar_lat: word-interleaved L2 crossbar with per-bank round-robin and fixed-latency responses.
// Per-initiator stall counters are built only when HCI_L2_XBAR_STALL_CNT_EN is defined.
module hci_l2_xbar_lat
  import hci_package::*;
#(
  parameter int N_CORES = 20,
  parameter int N_MEM   = 32,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1,
  localparam int BSW    = $clog2(N_MEM),
  localparam int AWM    = AW - 2 - BSW,
  localparam int CIW    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [N_CORES-1:0]           core_req_i,
  input  logic [N_CORES-1:0][AW-1:0]   core_add_i,
  input  logic [N_CORES-1:0]           core_wen_i,
  input  logic [N_CORES-1:0][DW-1:0]   core_wdata_i,
  input  logic [N_CORES-1:0][DW/8-1:0] core_be_i,
  output logic [N_CORES-1:0]           core_gnt_o,
  output logic [N_CORES-1:0]           core_r_valid_o,
  output logic [N_CORES-1:0][DW-1:0]   core_r_data_o,
  output logic [N_MEM-1:0]             mem_req_o,
  output logic [N_MEM-1:0][AWM-1:0]    mem_add_o,
  output logic [N_MEM-1:0]             mem_wen_o,
  output logic [N_MEM-1:0][DW-1:0]     mem_wdata_o,
  output logic [N_MEM-1:0][DW/8-1:0]   mem_be_o,
  input  logic [N_MEM-1:0]             mem_gnt_i,
  input  logic [N_MEM-1:0][DW-1:0]     mem_r_data_i,
  output logic [N_CORES-1:0][15:0]     stall_cnt_o
);
  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX || N_MEM < 2 || (N_MEM & (N_MEM - 1)) != 0 ||
      N_CORES > 2 ** IDX_W) begin : g_param_err
    $error("hci_l2_xbar_lat: MEM_LAT must be 1..4 and N_MEM a power of two >= 2");
  end
  logic [N_MEM-1:0][N_CORES-1:0] w_bank_req;
  logic [N_MEM-1:0][N_CORES-1:0] w_bank_gnt;
  logic [N_MEM-1:0][CIW-1:0]     w_win;
  logic [N_MEM-1:0]              w_fire;
  rsp_entry_t [N_MEM-1:0]        w_head;
  logic                          w_unused_lsb;
  always_comb begin
    w_bank_req   = '0;
    w_unused_lsb = 1'b0;
    for (int i = 0; i < N_CORES; i++) begin
      w_unused_lsb = w_unused_lsb ^ (^core_add_i[i][1:0]);
      for (int b = 0; b < N_MEM; b++)
        w_bank_req[b][i] = core_req_i[i] && (core_add_i[i][2+:BSW] == BSW'(b));
    end
  end
  for (genvar b = 0; b < N_MEM; b++) begin : g_bank
    rsp_entry_t r_pipe [MEM_LAT];
    hci_l2_rr_arbiter #(.N_REQ(N_CORES), .IW(CIW)) u_arb (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .i_req  (w_bank_req[b]),
      .i_en   (mem_gnt_i[b]),
      .o_gnt  (w_bank_gnt[b]),
      .o_idx  (w_win[b]),
      .o_fire (w_fire[b])
    );
    assign mem_req_o[b]   = w_fire[b];
    assign mem_add_o[b]   = w_fire[b] ? core_add_i[w_win[b]][AW-1:2+BSW] : '0;
    assign mem_wen_o[b]   = w_fire[b] & core_wen_i[w_win[b]];
    assign mem_wdata_o[b] = w_fire[b] ? core_wdata_i[w_win[b]] : '0;
    assign mem_be_o[b]    = w_fire[b] ? core_be_i[w_win[b]] : '0;
    // writes occupy a slot too so every grant yields exactly one r_valid pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) for (int k = 0; k < MEM_LAT; k++) r_pipe[k] <= '0;
      else begin
        r_pipe[0] <= '{valid: w_fire[b], idx: IDX_W'(w_win[b])};
        for (int k = 1; k < MEM_LAT; k++) r_pipe[k] <= r_pipe[k-1];
      end
    end
    assign w_head[b] = r_pipe[MEM_LAT-1];
  end
  always_comb begin
    core_gnt_o = '0;
    for (int b = 0; b < N_MEM; b++) core_gnt_o = core_gnt_o | w_bank_gnt[b];
  end
  always_comb begin
    core_r_valid_o = '0;
    core_r_data_o  = '0;
    for (int b = 0; b < N_MEM; b++)
      for (int i = 0; i < N_CORES; i++)
        if (w_head[b].valid && w_head[b].idx == IDX_W'(i)) begin
          core_r_valid_o[i] = 1'b1;
          core_r_data_o[i]  = mem_r_data_i[b];
        end
  end
`ifdef HCI_L2_XBAR_STALL_CNT_EN
  logic [N_CORES-1:0][15:0] r_stall;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_stall <= '0;
    else
      for (int i = 0; i < N_CORES; i++)
        if (core_req_i[i] && !core_gnt_o[i] && r_stall[i] != 16'hFFFF) r_stall[i] <= r_stall[i] + 16'd1;
  end
  assign stall_cnt_o = r_stall;
`else
  assign stall_cnt_o = '0;
`endif
endmodule

// File: tb/tb_hci_l2_xbar_lat.sv
// tb_hci_l2_xbar_lat: scoreboard bench driving two crossbars (MEM_LAT=2 and MEM_LAT=3) with shared stimulus.
module tb_hci_l2_xbar_lat;
  localparam int NC = 4;
  localparam int NM = 4;
`ifdef HCI_L2_XBAR_STALL_CNT_EN
  localparam int SEN = 1;
`else
  localparam int SEN = 0;
`endif
  typedef enum int {K_GNT, K_MREQ, K_MADD, K_MWEN, K_MWD, K_MBE, K_STALL, K_RSP} kind_e;
  typedef struct {int due; int dut; kind_e kind; int idx; logic [31:0] val; bit dchk;} exp_t;

  logic                clk = 1'b0;
  logic [1:0]          rst_n;
  logic [NC-1:0]       core_req, core_wen;
  logic [NC-1:0][31:0] core_add, core_wdata;
  logic [NC-1:0][3:0]  core_be;
  logic [NM-1:0]       mem_gnt;
  logic [NM-1:0][31:0] mem_rdata;
  logic [NC-1:0]       gnt [2];
  logic [NC-1:0]       rv [2];
  logic [NC-1:0][31:0] rdata [2];
  logic [NC-1:0][15:0] stall [2];
  logic [NM-1:0]       mreq [2];
  logic [NM-1:0]       mwen [2];
  logic [NM-1:0][27:0] madd [2];
  logic [NM-1:0][31:0] mwd [2];
  logic [NM-1:0][3:0]  mbe [2];
  exp_t sb[$];
  int cyc = 0;
  int tot = 0;
  int pass = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    hci_l2_xbar_lat #(.N_CORES(NC), .N_MEM(NM), .AW(32), .DW(32), .MEM_LAT(2 + g)) u_dut (
      .clk_i(clk), .rst_ni(rst_n[g]), .core_req_i(core_req), .core_add_i(core_add), .core_wen_i(core_wen),
      .core_wdata_i(core_wdata), .core_be_i(core_be), .core_gnt_o(gnt[g]), .core_r_valid_o(rv[g]),
      .core_r_data_o(rdata[g]), .mem_req_o(mreq[g]), .mem_add_o(madd[g]), .mem_wen_o(mwen[g]),
      .mem_wdata_o(mwd[g]), .mem_be_o(mbe[g]), .mem_gnt_i(mem_gnt), .mem_r_data_i(mem_rdata),
      .stall_cnt_o(stall[g]));
  end

  function automatic logic [31:0] bdat(int b);
    return (b == 0) ? 32'h0000_CAFE : 32'hB0B0_0000 + 32'(b);
  endfunction

  function automatic logic [31:0] probe(int d, kind_e k, int i);
    case (k)
      K_GNT:   return 32'(gnt[d]);
      K_MREQ:  return 32'(mreq[d]);
      K_MADD:  return 32'(madd[d][i]);
      K_MWEN:  return 32'(mwen[d][i]);
      K_MWD:   return mwd[d][i];
      K_MBE:   return 32'(mbe[d][i]);
      K_STALL: return 32'(stall[d][i]);
      default: return rdata[d][i];
    endcase
  endfunction

  task automatic chk(string nm, int d, int i, logic [31:0] act, logic [31:0] exp);
    tot++;
    if (act === exp) pass++;
    else $display("FAIL %s dut%0d[%0d] cycle %0d: got %h, expected %h", nm, d, i, cyc, act, exp);
  endtask

  always @(negedge clk) begin
    logic [NC-1:0] seen [2];
    exp_t e;
    seen[0] = '0;
    seen[1] = '0;
    for (int k = sb.size() - 1; k >= 0; k--) begin
      e = sb[k];
      if (e.due != cyc) continue;
      sb.delete(k);
      if (e.kind == K_RSP) begin
        seen[e.dut][e.idx] = 1'b1;
        if (e.dchk) chk("rsp_data", e.dut, e.idx, rdata[e.dut][e.idx], e.val);
      end else chk(e.kind.name(), e.dut, e.idx, probe(e.dut, e.kind, e.idx), e.val);
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NC; i++) begin
        chk("r_valid", d, i, 32'(rv[d][i]), 32'(seen[d][i]));
        if (!seen[d][i]) chk("rdata_idle", d, i, rdata[d][i], 32'h0);
      end
  end

  task automatic push(int d, kind_e k, int i, logic [31:0] v, int lat = 0, bit dc = 1'b1);
    exp_t e;
    e = '{due: cyc + lat, dut: d, kind: k, idx: i, val: v, dchk: dc};
    sb.push_back(e);
  endtask

  task automatic both(kind_e k, int i, logic [31:0] v);
    for (int d = 0; d < 2; d++) push(d, k, i, v);
  endtask

  task automatic rsp(int d, int core, int bank, bit dc = 1'b1);
    push(d, K_RSP, core, bdat(bank), 2 + d, dc);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    core_req = '0;
    core_wen = '0;
    core_add = '0;
    core_wdata = '0;
    core_be = '0;
  endtask

  task automatic req(int i, int bank, int word, bit rd);
    core_req[i]   = 1'b1;
    core_add[i]   = 32'(word * 16 + bank * 4 + i);
    core_wen[i]   = rd;
    core_wdata[i] = 32'hA000_0000 + 32'(i);
    core_be[i]    = 4'(15 - i);
  endtask

  initial begin
    rst_n = '0;
    core_req = '0;
    core_wen = '0;
    core_add = '0;
    core_wdata = '0;
    core_be = '0;
    mem_gnt = '1;
    for (int b = 0; b < NM; b++) mem_rdata[b] = bdat(b);
    repeat (2) @(posedge clk);
    #1 rst_n = '1;
    nxt();
    both(K_GNT, 0, 0);
    both(K_MREQ, 0, 0);
    for (int i = 0; i < NC; i++) both(K_STALL, i, 0);
    // core0 reads 0x10: bank 0, word 1
    nxt();
    req(0, 0, 1, 1'b1);
    both(K_GNT, 0, 1);
    both(K_MREQ, 0, 1);
    both(K_MADD, 0, 1);
    both(K_MADD, 1, 0);
    rsp(0, 0, 0);
    rsp(1, 0, 0);
    repeat (4) nxt();
    // bank 1 refuses for three cycles while core2 waits
    mem_gnt = 4'b1101;
    repeat (3) begin
      nxt();
      req(2, 1, 0, 1'b1);
      both(K_GNT, 0, 0);
      both(K_MREQ, 0, 0);
    end
    nxt();
    mem_gnt = '1;
    req(2, 1, 0, 1'b1);
    req(3, 1, 2, 1'b1);
    both(K_GNT, 0, 4);
    both(K_STALL, 2, 32'(3 * SEN));
    both(K_STALL, 3, 0);
    rsp(0, 2, 1);
    rsp(1, 2, 1);
    nxt();
    req(3, 1, 2, 1'b1);
    both(K_GNT, 0, 8);
    both(K_STALL, 3, 32'(SEN));
    rsp(0, 3, 1);
    rsp(1, 3, 1);
    repeat (4) nxt();
    // all cores hammer bank 1: rotation 0,1,2,3,0, then core0 alone back-to-back
    for (int k = 0; k < 5; k++) begin
      nxt();
      for (int i = 0; i < NC; i++) req(i, 1, i, 1'b1);
      both(K_GNT, 0, 32'(1 << (k % 4)));
      rsp(0, k % 4, 1);
      rsp(1, k % 4, 1);
    end
    repeat (2) begin
      nxt();
      req(0, 1, 7, 1'b1);
      both(K_GNT, 0, 1);
      rsp(0, 0, 1);
      rsp(1, 0, 1);
    end
    repeat (4) nxt();
    // cores 0..3 to banks 0..3 in one cycle; core3 writes
    nxt();
    for (int i = 0; i < NC; i++) req(i, i, 5, i != 3);
    both(K_GNT, 0, 15);
    both(K_MREQ, 0, 15);
    both(K_MADD, 2, 5);
    both(K_MWEN, 3, 0);
    both(K_MWEN, 0, 1);
    both(K_MWD, 3, 32'hA000_0003);
    both(K_MBE, 3, 32'hC);
    for (int i = 0; i < NC; i++) begin
      rsp(0, i, i, i != 3);
      rsp(1, i, i, i != 3);
    end
    repeat (4) nxt();
    // reset the MEM_LAT=3 instance one cycle after a grant: its response must vanish
    nxt();
    req(1, 2, 3, 1'b1);
    both(K_GNT, 0, 2);
    rsp(0, 1, 2);
    nxt();
    rst_n[1] = 1'b0;
    nxt();
    rst_n[1] = 1'b1;
    nxt();
    for (int i = 0; i < NC; i++) req(i, 2, i, 1'b1);
    push(0, K_GNT, 0, 4);
    push(1, K_GNT, 0, 1);
    rsp(0, 2, 2);
    rsp(1, 0, 2);
    repeat (6) nxt();
    $display("%0d/%0d checks passed", pass, tot);
    $finish;
  end
endmodule
